// File: rtl/axi_rd_burst_sched_if.sv
// Request, engine-command and status signals of the round-robin read-burst scheduler.
// The master modport is the scheduler's view; the slave modport is the requesters/engine side.
interface axi_rd_burst_sched_if #(
  parameter int NUM_CH   = 4,
  parameter int ADDR_W   = 32,
  parameter int NBURST_W = 16
);
  localparam int ID_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]          s_req_valid;
  logic [NUM_CH-1:0]          s_req_ready;
  logic [NUM_CH*ADDR_W-1:0]   s_req_addr;
  logic [NUM_CH*NBURST_W-1:0] s_req_nburst;
  logic                       o_txn_init;
  logic [ADDR_W-1:0]          o_txn_addr;
  logic [ID_W-1:0]            o_txn_id;
  logic                       i_axis_beat;
  logic                       i_axis_last;
  logic [NUM_CH-1:0]          o_req_done;
  logic                       o_err;
  logic                       o_busy;

  modport master (
    input  s_req_valid, s_req_addr, s_req_nburst, i_axis_beat, i_axis_last,
    output s_req_ready, o_txn_init, o_txn_addr, o_txn_id, o_req_done, o_err, o_busy
  );

  modport slave (
    output s_req_valid, s_req_addr, s_req_nburst, i_axis_beat, i_axis_last,
    input  s_req_ready, o_txn_init, o_txn_addr, o_txn_id, o_req_done, o_err, o_busy
  );
endinterface

// File: rtl/axi_rd_burst_sched.sv
// Round-robin scheduler sharing one AXI read-burst engine between NUM_CH descriptor slots.
// One burst per grant; completion is tracked from the engine's AXIS tlast handshake.
//
// state  | meaning
// S_IDLE | no slot holds work
// S_ARB  | pick next non-empty slot after rr pointer, latch id/addr
// S_ISSUE| one-cycle init pulse to the engine
// S_WAIT | count beats until tlast, or until the watchdog expires
module axi_rd_burst_sched #(
  parameter int NUM_CH    = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int BURST_LEN = 16,
  parameter int NBURST_W  = 16,
  parameter int TIMEOUT   = 4096
) (
  input  logic                 M_AXI_ACLK,
  input  logic                 M_AXI_ARESET,
  axi_rd_burst_sched_if.master bus
);
  localparam int ID_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * DATA_W / 8);
  localparam logic [WD_W-1:0]   WD_LOAD     = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_ISSUE, S_WAIT} state_t;

  state_t state_q, state_d;

  logic [NUM_CH-1:0]                slot_vld_q, slot_vld_d;
  logic [NUM_CH-1:0][ADDR_W-1:0]    slot_addr_q, slot_addr_d;
  logic [NUM_CH-1:0][NBURST_W-1:0]  slot_rem_q, slot_rem_d;
  logic [NUM_CH-1:0]                zpend_q, zpend_d;
  logic [NUM_CH-1:0]                done_q, done_d;
  logic                             err_q, err_d;
  logic                             rdy_en_q, rdy_en_d;
  logic [ID_W-1:0]                  rr_q, rr_d;
  logic [ID_W-1:0]                  id_q, id_d;
  logic [ADDR_W-1:0]                txn_addr_q, txn_addr_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic [WD_W-1:0]                  wd_q, wd_d;

  logic [NUM_CH-1:0] accept;
  logic [ID_W-1:0]   grant, cand;
  logic              found, burst_end, tmo;

  assign accept = bus.s_req_valid & bus.s_req_ready;

  // Cyclic search starting just after the last grant; the last winner is checked last.
  always_comb begin
    grant = rr_q;
    cand  = rr_q;
    found = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = ID_W'((int'(rr_q) + k) % NUM_CH);
      if (!found && slot_vld_q[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) state_q <= S_IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (|slot_vld_q) state_d = S_ARB;
      S_ARB:   state_d = found ? S_ISSUE : S_IDLE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (burst_end || tmo) state_d = (|slot_vld_d) ? S_ARB : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.o_txn_init  = (state_q == S_ISSUE);
    bus.o_txn_addr  = txn_addr_q;
    bus.o_txn_id    = id_q;
    bus.s_req_ready = rdy_en_q ? ~(slot_vld_q | zpend_q) : '0;
    bus.o_req_done  = done_q;
    bus.o_err       = err_q;
    bus.o_busy      = (state_q != S_IDLE) | (|slot_vld_q) | (|zpend_q);
  end

  always_comb begin
    slot_vld_d  = slot_vld_q;
    slot_addr_d = slot_addr_q;
    slot_rem_d  = slot_rem_q;
    zpend_d     = '0;
    done_d      = '0;
    err_d       = 1'b0;
    rdy_en_d    = 1'b1;
    rr_d        = rr_q;
    id_d        = id_q;
    txn_addr_d  = txn_addr_q;
    cnt_d       = cnt_q;
    wd_d        = wd_q;
    burst_end   = 1'b0;
    tmo         = 1'b0;

    // Zero-length descriptors hold ready low for one cycle while done pulses.
    for (int i = 0; i < NUM_CH; i++) begin
      if (accept[i]) begin
        if (bus.s_req_nburst[i*NBURST_W +: NBURST_W] == '0) begin
          zpend_d[i] = 1'b1;
          done_d[i]  = 1'b1;
        end else begin
          slot_vld_d[i]  = 1'b1;
          slot_addr_d[i] = bus.s_req_addr[i*ADDR_W +: ADDR_W];
          slot_rem_d[i]  = bus.s_req_nburst[i*NBURST_W +: NBURST_W];
        end
      end
    end

    case (state_q)
      S_ARB: begin
        if (found) begin
          rr_d       = grant;
          id_d       = grant;
          txn_addr_d = slot_addr_q[grant];
        end
      end
      S_ISSUE: begin
        cnt_d = '0;
        wd_d  = WD_LOAD;
      end
      S_WAIT: begin
        if (bus.i_axis_beat && bus.i_axis_last) begin
          burst_end          = 1'b1;
          err_d              = (cnt_q != CNT_W'(BURST_LEN - 1));
          slot_rem_d[id_q]   = slot_rem_q[id_q] - NBURST_W'(1);
          slot_addr_d[id_q]  = slot_addr_q[id_q] + BURST_BYTES;
          if (slot_rem_q[id_q] == NBURST_W'(1)) begin
            slot_vld_d[id_q] = 1'b0;
            done_d[id_q]     = 1'b1;
          end
        end else begin
          if (bus.i_axis_beat) begin
            if (cnt_q == CNT_W'(BURST_LEN)) err_d = 1'b1;
            else                            cnt_d = cnt_q + CNT_W'(1);
          end
          // Watchdog expiry drops the whole descriptor without a done pulse.
          if (TIMEOUT > 0 && wd_q == '0) begin
            tmo              = 1'b1;
            err_d            = 1'b1;
            slot_vld_d[id_q] = 1'b0;
          end else begin
            wd_d = wd_q - WD_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      slot_vld_q  <= '0;
      slot_addr_q <= '0;
      slot_rem_q  <= '0;
      zpend_q     <= '0;
      done_q      <= '0;
      err_q       <= 1'b0;
      rdy_en_q    <= 1'b0;
      rr_q        <= ID_W'(NUM_CH - 1);
      id_q        <= '0;
      txn_addr_q  <= '0;
      cnt_q       <= '0;
      wd_q        <= '0;
    end else begin
      slot_vld_q  <= slot_vld_d;
      slot_addr_q <= slot_addr_d;
      slot_rem_q  <= slot_rem_d;
      zpend_q     <= zpend_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdy_en_q    <= rdy_en_d;
      rr_q        <= rr_d;
      id_q        <= id_d;
      txn_addr_q  <= txn_addr_d;
      cnt_q       <= cnt_d;
      wd_q        <= wd_d;
    end
  end
endmodule
